// File: rtl/huffman_decoder_pkg.sv
// Shared constants, FSM encoding and helpers for the Huffman decoder slice.
// Symbol index width is fixed at 3 bits regardless of NSYM.
package huffman_decoder_pkg;

    localparam int unsigned NSYM = 6;
    localparam int unsigned CW   = 8;
    localparam int unsigned IDXW = 3;
    localparam int unsigned LENW = 4;

    localparam logic [LENW-1:0] LEN_MAX = LENW'(CW);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // Mask with the low 'len' bits set; built bitwise so len == CW needs no wider temp.
    function automatic logic [CW-1:0] mask_of_len(input logic [LENW-1:0] len);
        logic [CW-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < CW; i++) begin
            m[i] = (i < 32'(len));
        end
        return m;
    endfunction

endpackage

// File: rtl/huffman_decoder_if.sv
// Table-load, serial-bit and symbol-output signals of the Huffman decoder.
// The master side drives tables and bits; the slave side is the decoder.
interface huffman_decoder_if;
    import huffman_decoder_pkg::*;

    logic                 tbl_valid;
    logic [NSYM*CW-1:0]   hc_tbl;
    logic [NSYM*CW-1:0]   m_tbl;
    logic                 bit_in;
    logic                 bit_valid;
    logic                 bit_ready;
    logic                 sym_valid;
    logic [IDXW-1:0]      sym_idx;
    logic                 err;
    logic                 pending;

    modport master (
        output tbl_valid, hc_tbl, m_tbl, bit_in, bit_valid,
        input  bit_ready, sym_valid, sym_idx, err, pending
    );

    modport slave (
        input  tbl_valid, hc_tbl, m_tbl, bit_in, bit_valid,
        output bit_ready, sym_valid, sym_idx, err, pending
    );

endinterface

// File: rtl/huffman_decoder_match.sv
// Combinational code-table lookup: finds the lowest-index entry whose length
// equals nlen and whose code equals the masked accumulator.
module huffman_match
    import huffman_decoder_pkg::*;
(
    input  logic [CW-1:0]       nacc_i,
    input  logic [LENW-1:0]     nlen_i,
    input  logic [NSYM*CW-1:0]  hc_i,
    input  logic [NSYM*CW-1:0]  m_i,
    output logic                hit_o,
    output logic [IDXW-1:0]     idx_o
);

    logic [CW-1:0] want_mask;

    always_comb begin
        want_mask = mask_of_len(nlen_i);
        hit_o     = 1'b0;
        idx_o     = '0;
        for (int unsigned i = 0; i < NSYM; i++) begin
            if (!hit_o
                && (m_i[i*CW +: CW] != '0)
                && (m_i[i*CW +: CW] == want_mask)
                && ((nacc_i & m_i[i*CW +: CW]) == hc_i[i*CW +: CW])) begin
                hit_o = 1'b1;
                idx_o = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/huffman_decoder.sv
// Serial MSB-first Huffman decoder: latches a HC/M code table, shifts in one
// bit per transfer and emits a registered one-cycle symbol pulse on a match.
module huffman_decoder
    import huffman_decoder_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    huffman_decoder_if.slave   bus
);

    state_t               state_q, state_d;
    logic [NSYM*CW-1:0]   hc_q, hc_d;
    logic [NSYM*CW-1:0]   m_q, m_d;
    // Only CW-1 bits are held: a full CW-bit accumulation either matches or errors.
    logic [CW-2:0]        acc_q, acc_d;
    logic [LENW-1:0]      len_q, len_d;
    logic                 err_q, err_d;
    logic                 sym_valid_q, sym_valid_d;
    logic [IDXW-1:0]      sym_idx_q, sym_idx_d;
    logic                 pending_q, pending_d;

    logic [CW-1:0]        nacc;
    logic [LENW-1:0]      nlen;
    logic                 hit;
    logic [IDXW-1:0]      hit_idx;
    logic                 xfer;
    logic                 overflow;

    assign nacc     = {acc_q, bus.bit_in};
    assign nlen     = len_q + 1'b1;
    assign xfer     = bus.bit_valid & bus.bit_ready & ~bus.tbl_valid;
    assign overflow = xfer & ~hit & (nlen == LEN_MAX);

    huffman_match u_match (
        .nacc_i (nacc),
        .nlen_i (nlen),
        .hc_i   (hc_q),
        .m_i    (m_q),
        .hit_o  (hit),
        .idx_o  (hit_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.tbl_valid) begin
            state_d = ST_RUN;
        end else if ((state_q == ST_RUN) && overflow) begin
            state_d = ST_ERR;
        end
    end

    always_comb begin
        bus.bit_ready = (state_q == ST_RUN);
    end

    always_comb begin
        hc_d        = hc_q;
        m_d         = m_q;
        acc_d       = acc_q;
        len_d       = len_q;
        err_d       = err_q;
        sym_valid_d = 1'b0;
        sym_idx_d   = sym_idx_q;
        if (bus.tbl_valid) begin
            hc_d  = bus.hc_tbl;
            m_d   = bus.m_tbl;
            acc_d = '0;
            len_d = '0;
            err_d = 1'b0;
        end else if (xfer) begin
            if (hit) begin
                sym_valid_d = 1'b1;
                sym_idx_d   = hit_idx;
                acc_d       = '0;
                len_d       = '0;
            end else if (overflow) begin
                err_d = 1'b1;
                acc_d = '0;
                len_d = '0;
            end else begin
                acc_d = nacc[CW-2:0];
                len_d = nlen;
            end
        end
        pending_d = (len_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc_q        <= '0;
            m_q         <= '0;
            acc_q       <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            sym_valid_q <= 1'b0;
            sym_idx_q   <= '0;
            pending_q   <= 1'b0;
        end else begin
            hc_q        <= hc_d;
            m_q         <= m_d;
            acc_q       <= acc_d;
            len_q       <= len_d;
            err_q       <= err_d;
            sym_valid_q <= sym_valid_d;
            sym_idx_q   <= sym_idx_d;
            pending_q   <= pending_d;
        end
    end

    assign bus.sym_valid = sym_valid_q;
    assign bus.sym_idx   = sym_idx_q;
    assign bus.err       = err_q;
    assign bus.pending   = pending_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed self-checking bench for huffman_decoder using a hand-built
// prefix code table; inputs change and outputs are sampled 1ns after posedge.
module tb_huffman_decoder;
    import huffman_decoder_pkg::*;

    localparam logic [NSYM*CW-1:0] FULL_HC = {8'h04, 8'h05, 8'h03, 8'h00, 8'h01, 8'h01};
    localparam logic [NSYM*CW-1:0] FULL_M  = {8'h1F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};
    localparam logic [NSYM*CW-1:0] NO2_M   = {8'h1F, 8'h1F, 8'h0F, 8'h00, 8'h03, 8'h01};

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    logic [7:0] code_hc  [NSYM] = '{8'h01, 8'h01, 8'h00, 8'h03, 8'h05, 8'h04};
    int         code_len [NSYM] = '{1, 2, 3, 4, 5, 5};

    huffman_decoder_if hif ();

    huffman_decoder u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_table(input logic [NSYM*CW-1:0] hc, input logic [NSYM*CW-1:0] m);
        hif.hc_tbl    = hc;
        hif.m_tbl     = m;
        hif.tbl_valid = 1'b1;
        tick();
        hif.tbl_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic exp_sv, input int exp_idx,
                            input logic exp_pend, input string tag);
        hif.bit_in    = b;
        hif.bit_valid = 1'b1;
        tick();
        hif.bit_valid = 1'b0;
        check({tag, ".sym_valid"}, 32'(hif.sym_valid), 32'(exp_sv));
        check({tag, ".pending"}, 32'(hif.pending), 32'(exp_pend));
        if (exp_sv) check({tag, ".sym_idx"}, 32'(hif.sym_idx), 32'(exp_idx));
    endtask

    task automatic send_sym(input int s, input string tag);
        for (int j = code_len[s] - 1; j >= 0; j--) begin
            send_bit(code_hc[s][j], (j == 0), s, (j != 0), tag);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        reset         = 1'b1;
        hif.tbl_valid = 1'b0;
        hif.hc_tbl    = '0;
        hif.m_tbl     = '0;
        hif.bit_in    = 1'b0;
        hif.bit_valid = 1'b0;
        #2;
        check("rst.bit_ready", 32'(hif.bit_ready), 0);
        check("rst.sym_valid", 32'(hif.sym_valid), 0);
        check("rst.sym_idx",   32'(hif.sym_idx), 0);
        check("rst.err",       32'(hif.err), 0);
        check("rst.pending",   32'(hif.pending), 0);
        tick();
        reset = 1'b0;

        // IDLE ignores bits
        hif.bit_in    = 1'b1;
        hif.bit_valid = 1'b1;
        tick();
        tick();
        hif.bit_valid = 1'b0;
        check("idle.sym_valid", 32'(hif.sym_valid), 0);
        check("idle.pending",   32'(hif.pending), 0);
        check("idle.bit_ready", 32'(hif.bit_ready), 0);

        load_table(FULL_HC, FULL_M);
        check("load.bit_ready", 32'(hif.bit_ready), 1);
        check("load.err",       32'(hif.err), 0);

        // back-to-back stream of all six codes
        for (int s = 0; s < NSYM; s++) send_sym(s, $sformatf("b2b%0d", s));
        tick();
        check("b2b.idle_sv", 32'(hif.sym_valid), 0);

        // bit_valid toggling during "0011"
        for (int j = 3; j >= 0; j--) begin
            send_bit(code_hc[3][j], (j == 0), 3, (j != 0), $sformatf("tog%0d", j));
            hif.bit_in = ~code_hc[3][j];
            tick();
            check($sformatf("tog%0d.gap_sv", j), 32'(hif.sym_valid), 0);
            check($sformatf("tog%0d.gap_pend", j), 32'(hif.pending), 32'(j != 0));
        end

        // overflow with symbol 2 disabled
        load_table(FULL_HC, NO2_M);
        for (int k = 0; k < 7; k++) begin
            send_bit(1'b0, 1'b0, 0, 1'b1, $sformatf("ovf%0d", k));
            check($sformatf("ovf%0d.err", k), 32'(hif.err), 0);
        end
        send_bit(1'b0, 1'b0, 0, 1'b0, "ovf7");
        check("ovf7.err",       32'(hif.err), 1);
        check("ovf7.bit_ready", 32'(hif.bit_ready), 0);
        for (int k = 0; k < 3; k++) begin
            send_bit(1'b1, 1'b0, 0, 1'b0, $sformatf("errhold%0d", k));
            check($sformatf("errhold%0d.err", k), 32'(hif.err), 1);
        end

        // recover from ERR by reload
        load_table(FULL_HC, FULL_M);
        check("rec.err",       32'(hif.err), 0);
        check("rec.bit_ready", 32'(hif.bit_ready), 1);
        send_sym(1, "rec");

        // mid-code reload with a bit offered in the load cycle
        send_bit(1'b0, 1'b0, 0, 1'b1, "mid0");
        send_bit(1'b0, 1'b0, 0, 1'b1, "mid1");
        send_bit(1'b1, 1'b0, 0, 1'b1, "mid2");
        hif.bit_in    = 1'b1;
        hif.bit_valid = 1'b1;
        load_table(FULL_HC, FULL_M);
        hif.bit_valid = 1'b0;
        check("mid.pending",   32'(hif.pending), 0);
        check("mid.sym_valid", 32'(hif.sym_valid), 0);
        check("mid.err",       32'(hif.err), 0);
        send_sym(0, "mid.after");

        // asynchronous reset mid-code
        send_bit(1'b0, 1'b0, 0, 1'b1, "ar0");
        send_bit(1'b0, 1'b0, 0, 1'b1, "ar1");
        #2;
        reset = 1'b1;
        #1;
        check("ar.bit_ready", 32'(hif.bit_ready), 0);
        check("ar.pending",   32'(hif.pending), 0);
        check("ar.sym_valid", 32'(hif.sym_valid), 0);
        check("ar.sym_idx",   32'(hif.sym_idx), 0);
        check("ar.err",       32'(hif.err), 0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send_bit(1'b1, 1'b0, 0, 1'b0, $sformatf("ar.idle%0d", k));
            check($sformatf("ar.idle%0d.rdy", k), 32'(hif.bit_ready), 0);
        end
        load_table(FULL_HC, FULL_M);
        check("ar.reload_rdy", 32'(hif.bit_ready), 1);
        send_sym(5, "ar.after");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
